// File: rtl/mem_master_pkg.sv
// Shared types for the mem_master bus initiator: FSM state encoding and the
// registered request. The request struct is sized by the package default widths.
package mem_master_pkg;

   localparam int DATA_W_DEF = 16;
   localparam int ADDR_W_DEF = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   typedef struct packed {
      logic                  wr;
      logic [ADDR_W_DEF-1:0] addr;
      logic [ADDR_W_DEF-1:0] len;
      logic [DATA_W_DEF-1:0] wdata;
   } req_t;

endpackage

// File: rtl/mem_master_stats.sv
// Saturating activity counters for mem_master; only instantiated when
// MEM_MASTER_STATS_EN is defined.
module mem_master_stats (
   input  logic        clk,
   input  logic        reset,
   input  logic        rd_inc,
   input  logic        wr_inc,
   output logic [15:0] rd_beats,
   output logic [15:0] wr_count
);

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_beats <= '0;
         wr_count <= '0;
      end else begin
         if (rd_inc && (rd_beats != 16'hFFFF)) rd_beats <= rd_beats + 16'd1;
         if (wr_inc && (wr_count != 16'hFFFF)) wr_count <= wr_count + 16'd1;
      end
   end

endmodule

// File: rtl/mem_master.sv
// Single-outstanding initiator for the 16x16 single-port memory bus: single-beat
// writes and wrapping read bursts. Optional counters via MEM_MASTER_STATS_EN.
//
//   state | meaning
//   IDLE  | ready for a request
//   ISSUE | one bus access cycle (read or write)
//   WAIT  | counting READ_LAT cycles before sampling mem_rdata
//   RESP  | read beat presented, held until rsp_ready
module mem_master
   import mem_master_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int READ_LAT = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_wr,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [ADDR_W-1:0] req_len,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic [ADDR_W-1:0] rsp_addr,
   output logic              rsp_last,
   output logic              wr_done,
   output logic              mem_sel,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
`ifdef MEM_MASTER_STATS_EN
   ,
   output logic [15:0]       rd_beats,
   output logic [15:0]       wr_count
`endif
);

   state_t            state_q, state_d;
   req_t              req_q;
   logic [1:0]        lat_q;
   logic              run_q;
   logic              wr_done_q;
   logic [DATA_W-1:0] rsp_data_q;
   logic              last_beat;

   assign last_beat = (req_q.len == '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         req_q      <= '0;
         lat_q      <= '0;
         run_q      <= 1'b0;
         wr_done_q  <= 1'b0;
         rsp_data_q <= '0;
      end else begin
         state_q   <= state_d;
         run_q     <= 1'b1;
         wr_done_q <= (state_q == ISSUE) && req_q.wr;
         case (state_q)
            IDLE: begin
               if (req_valid && req_ready)
                  req_q <= '{wr: req_wr, addr: req_addr, len: req_len, wdata: req_wdata};
            end
            ISSUE: lat_q <= 2'(READ_LAT - 1);
            WAIT: begin
               if (lat_q == '0) rsp_data_q <= mem_rdata;
               else             lat_q      <= lat_q - 2'd1;
            end
            RESP: begin
               // Address and remaining count advance only once the beat is taken.
               if (rsp_ready && !last_beat) begin
                  req_q.addr <= req_q.addr + 1'b1;
                  req_q.len  <= req_q.len - 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_d   = state_q;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      rsp_last  = 1'b0;
      mem_sel   = 1'b0;
      mem_wr    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      case (state_q)
         IDLE: begin
            req_ready = run_q;
            if (req_valid && run_q) state_d = ISSUE;
         end
         ISSUE: begin
            mem_sel   = 1'b1;
            mem_wr    = req_q.wr;
            mem_addr  = req_q.addr;
            mem_wdata = req_q.wdata;
            state_d   = req_q.wr ? IDLE : WAIT;
         end
         WAIT: begin
            if (lat_q == '0) state_d = RESP;
         end
         RESP: begin
            rsp_valid = 1'b1;
            rsp_last  = last_beat;
            if (rsp_ready) state_d = last_beat ? IDLE : ISSUE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign rsp_data = rsp_data_q;
   assign rsp_addr = req_q.addr;
   assign wr_done  = wr_done_q;

`ifdef MEM_MASTER_STATS_EN
   mem_master_stats u_stats (
      .clk      (clk),
      .reset    (reset),
      .rd_inc   (rsp_valid && rsp_ready),
      .wr_inc   (wr_done_q),
      .rd_beats (rd_beats),
      .wr_count (wr_count)
   );
`endif

endmodule

// File: tb/tb_mem_master.sv
// Directed bench for mem_master: two instances (READ_LAT 1 and 3), each with a
// latency-accurate memory model; read beats are checked against a scoreboard queue.
module tb_mem_master;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic [1:0]       req_valid, req_ready, req_wr, rsp_valid, rsp_ready, rsp_last;
   logic [1:0]       wr_done, mem_sel, mem_wr;
   logic [1:0][3:0]  req_addr, req_len, rsp_addr, mem_addr;
   logic [1:0][15:0] req_wdata, rsp_data, mem_wdata, mem_rdata;
`ifdef MEM_MASTER_STATS_EN
   logic [1:0][15:0] rd_beats, wr_count;
`endif

   for (genvar g = 0; g < 2; g++) begin : g_inst
      localparam int LAT = (g == 0) ? 1 : 3;
      logic [15:0] mem  [16];
      logic [15:0] pipe [4];

      mem_master #(.DATA_W(16), .ADDR_W(4), .READ_LAT(LAT)) dut (
         .clk       (clk),
         .reset     (reset),
         .req_valid (req_valid[g]),
         .req_ready (req_ready[g]),
         .req_wr    (req_wr[g]),
         .req_addr  (req_addr[g]),
         .req_len   (req_len[g]),
         .req_wdata (req_wdata[g]),
         .rsp_valid (rsp_valid[g]),
         .rsp_ready (rsp_ready[g]),
         .rsp_data  (rsp_data[g]),
         .rsp_addr  (rsp_addr[g]),
         .rsp_last  (rsp_last[g]),
         .wr_done   (wr_done[g]),
         .mem_sel   (mem_sel[g]),
         .mem_wr    (mem_wr[g]),
         .mem_addr  (mem_addr[g]),
         .mem_wdata (mem_wdata[g]),
         .mem_rdata (mem_rdata[g])
`ifdef MEM_MASTER_STATS_EN
         ,
         .rd_beats  (rd_beats[g]),
         .wr_count  (wr_count[g])
`endif
      );

      // Read data is valid only during the single cycle LAT cycles after the issue cycle.
      always @(posedge clk) begin
         if (mem_sel[g] && mem_wr[g]) mem[mem_addr[g]] <= mem_wdata[g];
         pipe[0] <= (mem_sel[g] && !mem_wr[g]) ? mem[mem_addr[g]] : 16'hxxxx;
         for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
      end
      assign mem_rdata[g] = pipe[LAT-1];
   end

   typedef struct {
      logic [15:0] data;
      logic [3:0]  addr;
      logic        last;
   } beat_t;

   beat_t       sb [$];
   logic [15:0] shadow [2][16];
   int          checks = 0;
   int          errors = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_ready(input int d, input string tag);
      int k = 0;
      while (!req_ready[d] && k < 20) begin
         step();
         k++;
      end
      if (!req_ready[d]) check({tag, "_ready_timeout"}, 64'd0, 64'd1);
   endtask

   task automatic do_write(input int d, input logic [3:0] a, input logic [15:0] v, input string tag);
      wait_ready(d, tag);
      req_valid[d] = 1'b1;
      req_wr[d]    = 1'b1;
      req_addr[d]  = a;
      req_len[d]   = 4'hF;
      req_wdata[d] = v;
      step();
      req_valid[d] = 1'b0;
      check({tag, "_issue"}, {mem_sel[d], mem_wr[d], mem_addr[d], mem_wdata[d], req_ready[d], wr_done[d]},
            {1'b1, 1'b1, a, v, 1'b0, 1'b0});
      step();
      check({tag, "_done"}, {mem_sel[d], mem_wr[d], wr_done[d], req_ready[d]}, 4'b0011);
      shadow[d][a] = v;
      step();
      check({tag, "_pulse"}, {25'd0, wr_done[d]}, 0);
   endtask

   // stop_after > 0 abandons the burst right after that many beats were taken.
   task automatic do_read(input int d, input logic [3:0] a, input logic [3:0] len, input int lat,
                          input int stall_beat, input int stop_after, input string tag);
      logic [3:0] ai;
      beat_t      e;
      int         k;
      for (int i = 0; i <= int'(len); i++) begin
         ai = a + 4'(i);
         sb.push_back('{data: shadow[d][ai], addr: ai, last: (i == int'(len))});
      end
      wait_ready(d, tag);
      req_valid[d] = 1'b1;
      req_wr[d]    = 1'b0;
      req_addr[d]  = a;
      req_len[d]   = len;
      req_wdata[d] = 16'h0;
      step();
      req_valid[d] = 1'b0;
      check({tag, "_issue"}, {mem_sel[d], mem_wr[d], mem_addr[d], req_ready[d]}, {1'b1, 1'b0, a, 1'b0});
      for (int i = 0; i <= int'(len); i++) begin
         k = 0;
         while (!rsp_valid[d] && k < 20) begin
            step();
            k++;
         end
         check($sformatf("%s_lat%0d", tag, i), k, lat + 1);
         if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 64'd0, 64'd1);
            return;
         end
         e = sb.pop_front();
         check($sformatf("%s_beat%0d", tag, i), {rsp_valid[d], rsp_data[d], rsp_addr[d], rsp_last[d]},
               {1'b1, e.data, e.addr, e.last});
         if (i == stall_beat) begin
            rsp_ready[d] = 1'b0;
            req_valid[d] = 1'b1;
            req_wr[d]    = 1'b1;
            req_addr[d]  = 4'h3;
            req_wdata[d] = 16'hDEAD;
            for (int s = 0; s < 5; s++) begin
               step();
               check($sformatf("%s_stall%0d", tag, s),
                     {rsp_valid[d], rsp_data[d], rsp_addr[d], rsp_last[d], mem_sel[d], req_ready[d]},
                     {1'b1, e.data, e.addr, e.last, 1'b0, 1'b0});
            end
            req_valid[d] = 1'b0;
            rsp_ready[d] = 1'b1;
         end
         step();
         if (stop_after > 0 && i + 1 == stop_after) return;
      end
      check({tag, "_end"}, {req_ready[d], rsp_valid[d], 30'(sb.size())}, {1'b1, 1'b0, 30'd0});
   endtask

   logic seen;

   initial begin
      reset     = 1'b1;
      req_valid = '0;
      req_wr    = '0;
      req_addr  = '0;
      req_len   = '0;
      req_wdata = '0;
      rsp_ready = 2'b11;
      step(3);
      check("reset_outs",
            {req_ready, rsp_valid, rsp_data, rsp_addr, rsp_last, wr_done, mem_sel, mem_wr, mem_addr, mem_wdata},
            '0);
      reset = 1'b0;
      step();
      check("ready_after_reset", {30'd0, req_ready}, 2'b11);

      // Write then read back
      do_write(0, 4'h1, 16'hA5A5, "wr1");
      do_read(0, 4'h1, 4'h0, 1, -1, 0, "rd1");

      // Wrapping burst with backpressure on the middle beat
      do_write(0, 4'hF, 16'h5A5A, "wrF");
      do_write(0, 4'h0, 16'h1111, "wr0");
      do_write(0, 4'h1, 16'h2222, "wr1b");
      do_read(0, 4'hF, 4'h2, 1, 1, 0, "wrap");

      // Full-length burst touching every address once
      for (int i = 0; i < 16; i++) do_write(0, 4'(i), 16'hC000 + 16'(i * 37), $sformatf("fill%0d", i));
      do_read(0, 4'h5, 4'hF, 1, -1, 0, "full");

      // Reset in the middle of a burst
      do_read(0, 4'h0, 4'h7, 1, -1, 2, "abort");
      reset = 1'b1;
      step();
      check("abort_reset_outs",
            {req_ready[0], rsp_valid[0], rsp_data[0], rsp_addr[0], rsp_last[0], wr_done[0],
             mem_sel[0], mem_wr[0], mem_addr[0], mem_wdata[0]}, '0);
      reset = 1'b0;
      sb.delete();
      step();
      check("abort_ready", {31'd0, req_ready[0]}, 1);
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (rsp_valid[0] || mem_sel[0] || wr_done[0]) seen = 1'b1;
      end
      check("abort_quiet", {31'd0, seen}, 0);

      // Latency 3 instance
      do_write(1, 4'h7, 16'hBEEF, "l3_wr7");
      do_write(1, 4'h8, 16'h1234, "l3_wr8");
      do_read(1, 4'h7, 4'h1, 3, -1, 0, "l3_rd");

`ifdef MEM_MASTER_STATS_EN
      reset = 1'b1;
      step(2);
      reset = 1'b0;
      step();
      do_write(0, 4'h2, 16'h0102, "st_w0");
      do_write(0, 4'h3, 16'h0304, "st_w1");
      do_write(0, 4'h4, 16'h0506, "st_w2");
      do_read(0, 4'h2, 4'h3, 1, -1, 0, "st_rd");
      check("stats_counts", {wr_count[0], rd_beats[0]}, {16'd3, 16'd4});
      reset = 1'b1;
      step();
      check("stats_reset", {wr_count, rd_beats}, '0);
      reset = 1'b0;
      step();
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
